fetch_req_ctrl: RTL

Front-end fetch controller that sits directly upstream of the instruction-queue FIFO. It generates sequential PCs and issues in-order requests to instruction memory. It buffers the returned instructions and pushes {pc, instr} pairs into the instruction queue over a valid/ready handshake. On a redirect from the back end it discards stale in-flight responses.

---
 rtl/fetch_req_ctrl_if.sv | 33 +++
 rtl/fetch_req_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/fetch_req_ctrl_if.sv
// Fetch controller bus: redirect input, instruction-memory request/response and
// instruction-queue enqueue handshake, grouped for the fetch_req_ctrl port list.
interface fetch_req_ctrl_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned RESP_DEPTH  = 4
);
  localparam int unsigned CntW = $clog2(RESP_DEPTH) + 1;

  logic                              redirect_valid;
  logic [ADDR_WIDTH-1:0]             redirect_pc;
  logic                              imem_req_valid;
  logic                              imem_req_ready;
  logic [ADDR_WIDTH-1:0]             imem_req_addr;
  logic                              imem_resp_valid;
  logic [INSTR_WIDTH-1:0]            imem_resp_data;
  logic                              enq_valid;
  logic                              enq_ready;
  logic [ADDR_WIDTH+INSTR_WIDTH-1:0] enq_data;
  logic [CntW-1:0]                   inflight;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data,
           enq_ready,
    output imem_req_valid, imem_req_addr, enq_valid, enq_data, inflight
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data,
           enq_ready,
    input  imem_req_valid, imem_req_addr, enq_valid, enq_data, inflight
  );
endinterface

// File: rtl/fetch_req_ctrl.sv
// Sequential fetch request generator with a credit-limited response buffer that
// pushes {pc, instr} pairs to the instruction queue and drops stale responses on redirect.
module fetch_req_ctrl #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           RESP_DEPTH  = 4
) (
  input logic              clk,
  input logic              rst_aL,
  fetch_req_ctrl_if.master bus
);
  localparam int unsigned IdxW = $clog2(RESP_DEPTH);
  localparam int unsigned CntW = IdxW + 1;
  localparam int unsigned EntW = ADDR_WIDTH + INSTR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PcStep   = ADDR_WIDTH'(4);
  localparam logic [CntW:0]         DepthCmp = (CntW + 1)'(RESP_DEPTH);
  localparam logic [CntW-1:0]       CntOne   = CntW'(1);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e                st_q, st_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]       inflight_q, inflight_d;
  logic [CntW-1:0]       drop_q, drop_d;
  logic [CntW-1:0]       wr_q, wr_d;
  logic [CntW-1:0]       rd_q, rd_d;
  logic [EntW-1:0]       buf_q [RESP_DEPTH];

  logic [CntW-1:0] count;
  logic            credit;
  logic            req_ok;
  logic            req_fire;
  logic            resp_keep;
  logic            pop;

  // Outstanding plus buffered entries never exceed the buffer, so responses always fit.
  assign count    = wr_q - rd_q;
  assign credit   = ({1'b0, inflight_q} + {1'b0, count}) < DepthCmp;
  assign req_ok   = ~bus.redirect_valid & credit;
  assign req_fire = req_ok & bus.imem_req_ready;

  assign bus.imem_req_valid = rst_aL & req_ok;
  assign bus.imem_req_addr  = pc_q;
  assign bus.enq_valid      = ~bus.redirect_valid & (count != '0);
  assign bus.enq_data       = buf_q[rd_q[IdxW-1:0]];
  assign bus.inflight       = inflight_q;

  assign pop       = bus.enq_valid & bus.enq_ready;
  assign resp_keep = bus.imem_resp_valid & ~bus.redirect_valid & (st_q == StRun);

  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    inflight_d = inflight_q + CntW'(req_fire) - CntW'(bus.imem_resp_valid);
    if (bus.redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old stream.
      pc_d      = bus.redirect_pc;
      resp_pc_d = bus.redirect_pc;
      drop_d    = inflight_q - CntW'(bus.imem_resp_valid);
      wr_d      = '0;
      rd_d      = '0;
    end else begin
      if (req_fire) pc_d = pc_q + PcStep;
      if (bus.imem_resp_valid && st_q == StDrain) drop_d = drop_q - CntOne;
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + PcStep;
        wr_d      = wr_q + CntOne;
      end
      if (pop) rd_d = rd_q + CntOne;
    end
    st_d = (drop_d != '0) ? StDrain : StRun;
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      st_q       <= StRun;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int unsigned i = 0; i < RESP_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      st_q       <= st_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      if (resp_keep) buf_q[wr_q[IdxW-1:0]] <= {resp_pc_q, bus.imem_resp_data};
    end
  end
endmodule
